// File: rtl/piso_arbiter_ctrl_if.sv
// Bus bundle between two requesters and the parallel-in/serial-out arbiter.
interface piso_arbiter_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             pause;
    logic             gnt0;
    logic             gnt1;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             owner;
    logic             busy;

    // Requester/environment side.
    modport master (
        output req0, data0, req1, data1, pause,
        input  gnt0, gnt1, serial_out, serial_valid, frame_start, owner, busy
    );

    // Arbiter side.
    modport slave (
        input  req0, data0, req1, data1, pause,
        output gnt0, gnt1, serial_out, serial_valid, frame_start, owner, busy
    );
endinterface

// File: rtl/piso_arbiter_ctrl.sv
// Two-requester round-robin arbiter feeding a single parallel-in/serial-out
// shift register. Grants are combinational and issued only in accept slots
// (idle, or on the last bit of a frame) so frames can run back to back.
module piso_arbiter_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    piso_arbiter_ctrl_if.slave  bus
);
    localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    // Low for the first cycle after reset so no grant can leak out there.
    logic             armed_q;

    logic             slot_c;
    logic             win1_c;
    logic             shifting_c;

    // Next-state, datapath update, grants and serial outputs.
    always_comb begin
        state_d          = state_q;
        sr_d             = sr_q;
        cnt_d            = cnt_q;
        owner_d          = owner_q;
        last_d           = last_q;
        bus.gnt0         = 1'b0;
        bus.gnt1         = 1'b0;
        bus.busy         = 1'b0;
        bus.serial_valid = 1'b0;
        bus.frame_start  = 1'b0;
        bus.serial_out   = 1'b0;

        slot_c = reset_n && armed_q && !bus.pause &&
                 ((state_q == IDLE) || (cnt_q == '0));

        // On a tie the requester that did not send last wins.
        if (bus.req0 && bus.req1) begin
            win1_c = ~last_q;
        end else begin
            win1_c = bus.req1;
        end

        shifting_c = (state_q == SHIFT) && !bus.pause;

        if (shifting_c) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = IDLE;
            end
        end

        if (slot_c && (bus.req0 || bus.req1)) begin
            bus.gnt0 = ~win1_c;
            bus.gnt1 = win1_c;
            sr_d     = win1_c ? bus.data1 : bus.data0;
            owner_d  = win1_c;
            last_d   = win1_c;
            cnt_d    = CNT_TOP;
            state_d  = SHIFT;
        end

        if (reset_n && (state_q == SHIFT)) begin
            bus.busy         = 1'b1;
            bus.serial_out   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
            bus.serial_valid = !bus.pause;
            bus.frame_start  = !bus.pause && (cnt_q == CNT_TOP);
        end
    end

    assign bus.owner = owner_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            armed_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_arbiter_ctrl.sv
// Directed bench for piso_arbiter_ctrl: MSB-first and LSB-first instances.
module tb_piso_arbiter_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    piso_arbiter_ctrl_if #(.WIDTH(4)) ma ();
    piso_arbiter_ctrl_if #(.WIDTH(4)) mb ();

    piso_arbiter_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (ma.slave)
    );

    piso_arbiter_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (mb.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Checks four consecutive frame bits on instance a, starting in the current cycle.
    task automatic expect_frame(input string tag, input logic [3:0] d, input logic own);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                settle();
            end
            check($sformatf("%s valid%0d", tag, i), ma.serial_valid, 1'b1);
            check($sformatf("%s bit%0d", tag, i), ma.serial_out, d[3-i]);
            check($sformatf("%s owner%0d", tag, i), ma.owner, own);
            check($sformatf("%s fs%0d", tag, i), ma.frame_start, (i == 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] stream;
        logic [3:0]  gorder;
        int          ng;
        int          fi;
        int          fb [4];

        ma.req0 = 1'b0; ma.req1 = 1'b0; ma.pause = 1'b0; ma.data0 = '0; ma.data1 = '0;
        mb.req0 = 1'b0; mb.req1 = 1'b0; mb.pause = 1'b0; mb.data0 = '0; mb.data1 = '0;
        rst_n = 1'b0;

        // Reset: no grant even with a request pending.
        ma.req0 = 1'b1; ma.data0 = 4'b1010;
        settle();
        check("rst gnt0", ma.gnt0, 1'b0);
        check("rst busy", ma.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        settle();
        check("post_rst gnt0", ma.gnt0, 1'b0);
        check("post_rst valid", ma.serial_valid, 1'b0);
        check("post_rst busy", ma.busy, 1'b0);
        check("post_rst sout", ma.serial_out, 1'b0);
        check("post_rst fs", ma.frame_start, 1'b0);
        check("post_rst owner", ma.owner, 1'b0);

        // Single frame 1010.
        tick(); settle();
        check("t1 gnt0", ma.gnt0, 1'b1);
        check("t1 gnt1", ma.gnt1, 1'b0);
        tick(); ma.req0 = 1'b0; settle();
        expect_frame("t1", 4'b1010, 1'b0);
        check("t1 last gnt0", ma.gnt0, 1'b0);
        tick(); settle();
        check("t1 end busy", ma.busy, 1'b0);
        check("t1 end valid", ma.serial_valid, 1'b0);

        // Tie after reset, then back-to-back frame.
        do_reset();
        ma.req0 = 1'b1; ma.data0 = 4'b0011;
        ma.req1 = 1'b1; ma.data1 = 4'b1100;
        settle();
        check("t2 gnt0", ma.gnt0, 1'b1);
        check("t2 gnt1", ma.gnt1, 1'b0);
        tick(); ma.req0 = 1'b0; settle();
        expect_frame("t2a", 4'b0011, 1'b0);
        check("t2 b2b gnt1", ma.gnt1, 1'b1);
        tick(); ma.req1 = 1'b0; settle();
        expect_frame("t2b", 4'b1100, 1'b1);
        tick(); settle();
        check("t2 end busy", ma.busy, 1'b0);

        // Fairness: both requests held for four frames.
        ma.req0 = 1'b1; ma.data0 = 4'b0011;
        ma.req1 = 1'b1; ma.data1 = 4'b1100;
        stream = '0; gorder = '0; ng = 0; fi = -1;
        for (int k = 0; k < 4; k++) fb[k] = 0;
        for (int c = 0; c <= 16; c++) begin
            if (ng == 4) begin
                ma.req0 = 1'b0;
                ma.req1 = 1'b0;
            end
            settle();
            if ((ma.gnt0 || ma.gnt1) && ng < 4) begin
                gorder[ng] = ma.gnt1;
                ng++;
            end
            if (ma.serial_valid) begin
                if (ma.frame_start) fi++;
                if (fi >= 0 && fi < 4) fb[fi]++;
                stream = {stream[14:0], ma.serial_out};
            end
            tick();
        end
        settle();
        check("t3 grants", ng, 4);
        check("t3 order", gorder, 4'b1010);
        check("t3 stream", stream, 16'h3C3C);
        for (int k = 0; k < 4; k++) check($sformatf("t3 bits%0d", k), fb[k], 4);
        check("t3 end busy", ma.busy, 1'b0);

        // Pause: idle hold, then a 3-cycle freeze after the second bit.
        ma.pause = 1'b1; ma.req0 = 1'b1; ma.data0 = 4'b1010;
        settle();
        check("t4 idle pause gnt0", ma.gnt0, 1'b0);
        tick(); settle();
        check("t4 idle pause busy", ma.busy, 1'b0);
        tick(); ma.pause = 1'b0; settle();
        check("t4 gnt0", ma.gnt0, 1'b1);
        tick(); ma.req0 = 1'b0; settle();
        check("t4 b0", ma.serial_out, 1'b1);
        check("t4 fs0", ma.frame_start, 1'b1);
        tick(); settle();
        check("t4 b1", ma.serial_out, 1'b0);
        check("t4 v1", ma.serial_valid, 1'b1);
        tick(); ma.pause = 1'b1; ma.req1 = 1'b1; ma.data1 = 4'b1111; settle();
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                tick();
                settle();
            end
            check($sformatf("t4 pv%0d", p), ma.serial_valid, 1'b0);
            check($sformatf("t4 pg0_%0d", p), ma.gnt0, 1'b0);
            check($sformatf("t4 pg1_%0d", p), ma.gnt1, 1'b0);
            check($sformatf("t4 pfs%0d", p), ma.frame_start, 1'b0);
            check($sformatf("t4 pbusy%0d", p), ma.busy, 1'b1);
        end
        tick(); ma.pause = 1'b0; ma.req1 = 1'b0; settle();
        check("t4 b2", ma.serial_out, 1'b1);
        check("t4 v2", ma.serial_valid, 1'b1);
        check("t4 fs2", ma.frame_start, 1'b0);
        tick(); settle();
        check("t4 b3", ma.serial_out, 1'b0);
        check("t4 v3", ma.serial_valid, 1'b1);
        tick(); settle();
        check("t4 end busy", ma.busy, 1'b0);

        // Reset in the middle of a frame, then a fresh grant to requester 1.
        ma.req0 = 1'b1; ma.data0 = 4'b1010;
        settle();
        check("t5 gnt0", ma.gnt0, 1'b1);
        tick(); ma.req0 = 1'b0; settle();
        check("t5 b0", ma.serial_out, 1'b1);
        tick(); settle();
        check("t5 b1", ma.serial_out, 1'b0);
        tick(); settle();
        check("t5 b2", ma.serial_out, 1'b1);
        rst_n = 1'b0;
        settle();
        check("t5 rst valid", ma.serial_valid, 1'b0);
        check("t5 rst busy", ma.busy, 1'b0);
        check("t5 rst sout", ma.serial_out, 1'b0);
        tick(); rst_n = 1'b1; ma.req1 = 1'b1; ma.data1 = 4'b0110; settle();
        check("t5 post gnt1", ma.gnt1, 1'b0);
        check("t5 post gnt0", ma.gnt0, 1'b0);
        check("t5 post busy", ma.busy, 1'b0);
        check("t5 post valid", ma.serial_valid, 1'b0);
        check("t5 post sout", ma.serial_out, 1'b0);
        check("t5 post fs", ma.frame_start, 1'b0);
        check("t5 post owner", ma.owner, 1'b0);
        tick(); settle();
        check("t5 gnt1", ma.gnt1, 1'b1);
        tick(); ma.req1 = 1'b0; settle();
        expect_frame("t5", 4'b0110, 1'b1);
        tick(); settle();
        check("t5 end busy", ma.busy, 1'b0);

        // LSB-first instance: 1000 leaves as 0,0,0,1.
        mb.req0 = 1'b1; mb.data0 = 4'b1000;
        settle();
        check("t6 gnt0", mb.gnt0, 1'b1);
        tick(); mb.req0 = 1'b0; settle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                settle();
            end
            check($sformatf("t6 valid%0d", i), mb.serial_valid, 1'b1);
            check($sformatf("t6 bit%0d", i), mb.serial_out, (i == 3));
        end
        tick(); settle();
        check("t6 end busy", mb.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/piso_arbiter_ctrl.md
PISO_ARBITER_CTRL -- requirements
Module: piso_arbiter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the shift-register and data width in bits (legal range 2-16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first, 0 shifts bit 0 out first.
REQ-003 SHALL have ports, clock and reset first:
  clock         input   1      single clock, all state on rising edge
  reset_n       input   1      synchronous, active-low reset
  req0          input   1      requester 0 wants to send a word
  data0         input   WIDTH  requester 0 word, stable while req0=1
  req1          input   1      requester 1 wants to send a word
  data1         input   WIDTH  requester 1 word, stable while req1=1
  pause         input   1      freeze shifting and arbitration
  gnt0          output  1      one-cycle accept of data0
  gnt1          output  1      one-cycle accept of data1
  serial_out    output  1      current serial bit
  serial_valid  output  1      serial_out carries a frame bit this cycle
  frame_start   output  1      first bit of a frame this cycle
  owner         output  1      requester id of the frame being shifted
  busy          output  1      a frame is in progress (state SHIFT)

Function
REQ-004 SHALL implement FSM states IDLE and SHIFT, with a bit counter of ceil(log2(WIDTH)) bits and a WIDTH-bit shift register.
REQ-005 SHALL define an accept slot as: pause=0 and (state IDLE, or state SHIFT with counter=0, i.e. last bit of the frame).
REQ-006 SHALL drive gnt0/gnt1 combinationally: asserted only in an accept slot, at most one high per cycle, only for a requester with req=1.
REQ-007 SHALL arbitrate round-robin: if only one req is high it wins; if both are high the requester other than last_owner wins.
REQ-008 SHALL, on a rising edge with gntX=1: load dataX into the shift register, set owner=X, set last_owner=X, set counter=WIDTH-1, enter SHIFT.
REQ-009 SHALL present a frame's first bit in the cycle after the grant (latency 1), then one bit per unpaused cycle, in MSB_FIRST order, WIDTH bits total.
REQ-010 SHALL assert serial_valid=1 exactly in SHIFT cycles with pause=0; frame_start=1 only in the first such cycle of each frame.
REQ-011 SHALL decrement the counter and advance the shift register only on edges where state=SHIFT and pause=0.
REQ-012 SHALL go IDLE after the last bit if no grant is issued in that slot; a grant in that slot starts the next frame with no idle gap.
REQ-013 SHALL, when pause=1: hold all state, drive gnt0=gnt1=0, serial_valid=0 and frame_start=0, and keep serial_out at the held bit.
REQ-014 SHALL make no commitment to a requester that drops req before being granted; no grant is issued and no state changes.
REQ-015 SHALL drive serial_out=0 in IDLE; busy=1 exactly when state=SHIFT.

Reset
REQ-016 SHALL, on a rising edge with reset_n=0 and regardless of pause or req, enter IDLE, clear the shift register and counter, set owner=0, and set last_owner=1 so requester 0 wins the first tie.
REQ-017 SHALL, during reset and in the first cycle after it, hold gnt0, gnt1, serial_out, serial_valid, frame_start and busy at 0; any frame in progress is discarded.

Verification
REQ-018 Single frame: after reset, req0=1 and data0=1010 at cycle N. Required: gnt0=1 at N; serial_out 1,0,1,0 at N+1..N+4; serial_valid=1 and owner=0 for N+1..N+4; frame_start=1 only at N+1; busy=0 at N+5.
REQ-019 Tie and back-to-back: req0=1 (0011) and req1=1 (1100) at N. Required: gnt0 at N; gnt1 at N+4; stream 0,0,1,1,1,1,0,0 at N+1..N+8 with no gap; owner switches to 1 at N+5.
REQ-020 Fairness: req0 and req1 held high for 4 frames. Required: grant order is 0,1,0,1, and each frame is exactly 4 valid bits.
REQ-021 Pause: pause=1 for 3 cycles after the second bit of frame 1010. Required: serial_valid=0 and no grants during the pause; the remaining bits 1,0 follow the pause, for 4 valid bits total.
REQ-022 Reset mid-frame: reset_n=0 for 1 cycle during the third bit. Required: all outputs are 0 the next cycle; a later req1 with 0110 is granted immediately and emits 0,1,1,0.
REQ-023 LSB-first: MSB_FIRST=0, data0=1000. Required: serial_out is 0,0,0,1.
